// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller.
// Owns the state and round-key registers and steps an external combinational
// round function and key-expansion step through ten rounds, one per cycle.
// The ciphertext is presented on a valid/ready handshake and held until taken.
module aes_round_sequencer (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_data_in,
  input  logic [127:0] i_key,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_data_out,
  output logic         o_busy,
  output logic [127:0] o_rf_state,
  output logic [127:0] o_rf_rkey,
  output logic         o_rf_final,
  input  logic [127:0] i_rf_result,
  output logic [127:0] o_ke_key,
  output logic [7:0]   o_ke_rcon,
  input  logic [127:0] i_ke_next_key,
  output logic [3:0]   o_round
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ROUND = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  state_t       r_state;
  state_t       w_state_next;
  logic [3:0]   r_round;
  logic [3:0]   w_round_next;
  logic [127:0] r_data;
  logic [127:0] w_data_next;
  logic [127:0] r_key;
  logic [127:0] w_key_next;
  logic [3:0]   w_round_disp;
  logic [7:0]   w_rcon;

  // State, round counter, cipher state and round key registers; reset clears all.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_round <= 4'd0;
      r_data  <= 128'd0;
      r_key   <= 128'd0;
    end else begin
      r_state <= w_state_next;
      r_round <= w_round_next;
      r_data  <= w_data_next;
      r_key   <= w_key_next;
    end
  end

  // Next-state logic: load with initial AddRoundKey, run ten rounds, hold result.
  always_comb begin
    w_state_next = r_state;
    w_round_next = r_round;
    w_data_next  = r_data;
    w_key_next   = r_key;
    case (r_state)
      S_IDLE: begin
        if (i_in_valid) begin
          // Round 0 is just the key whitening, done here on acceptance.
          w_data_next  = i_data_in ^ i_key;
          w_key_next   = i_key;
          w_round_next = 4'd1;
          w_state_next = S_ROUND;
        end else begin
          w_round_next = 4'd0;
        end
      end
      S_ROUND: begin
        if (r_round == 4'd0 || r_round > LAST_ROUND) begin
          // Counter outside 1..10 can only come from an upset; abandon the block.
          w_round_next = 4'd0;
          w_state_next = S_IDLE;
        end else begin
          w_data_next = i_rf_result;
          w_key_next  = i_ke_next_key;
          if (r_round == LAST_ROUND) begin
            w_round_next = 4'd0;
            w_state_next = S_DONE;
          end else begin
            w_round_next = r_round + 4'd1;
          end
        end
      end
      S_DONE: begin
        w_round_next = 4'd0;
        if (i_out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_round_next = 4'd0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_round_disp = (r_state == S_ROUND) ? r_round : 4'd0;

  // Round constant for the key-expansion step, zero outside the round loop.
  always_comb begin
    w_rcon = 8'h00;
    case (w_round_disp)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  // Host handshake outputs decode registered state only.
  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_DONE);
  assign o_busy      = (r_state == S_ROUND) || (r_state == S_DONE);
  assign o_data_out  = r_data;

  // Round-function and key-expansion hookups; the freshly expanded key is
  // used in the same cycle it is produced.
  assign o_rf_state  = r_data;
  assign o_rf_rkey   = i_ke_next_key;
  assign o_rf_final  = (r_state == S_ROUND) && (r_round == LAST_ROUND);
  assign o_ke_key    = r_key;
  assign o_ke_rcon   = w_rcon;
  assign o_round     = w_round_disp;

endmodule
